lookahead_multiport_ram: RTL and testbench
==========================================

LOOKAHEAD_MULTIPORT_RAM -- requirements
Module: lookahead_multiport_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8, range 8..256.
REQ-002 Parameter DEPTH, default 16, number of words; SHALL be 2..4096 and need not be a power of two.
REQ-003 Parameter NUM_RD_PORTS, default 2, number of independent read ports; range 1..8.
REQ-004 Parameter CLEAR_ON_RESET, default 1; 1 means zero-fill the memory after reset, 0 means skip the fill.
REQ-005 Derived ADDRESS_WIDTH = max(1, clog2(DEPTH)); BE_WIDTH = DATA_WIDTH/8.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 wr_address  input  ADDRESS_WIDTH  write word address.
REQ-009 wr_writedata  input  DATA_WIDTH  write data.
REQ-010 wr_byteenable  input  BE_WIDTH  per-byte write enable; bit k covers bits 8k+7..8k.
REQ-011 wr_write  input  1  write request.
REQ-012 wr_waitrequest  output  1  registered busy flag; 1 while reset is asserted or a clear is in progress.
REQ-013 clear  input  1  single-cycle request to zero-fill the whole memory.
REQ-014 rd_address  input  NUM_RD_PORTS*ADDRESS_WIDTH  packed read addresses; port i occupies slice i.
REQ-015 rd_readdata  output  NUM_RD_PORTS*DATA_WIDTH  packed registered read data; port i occupies slice i.

Function
REQ-016 States: CLEAR and READY; wr_waitrequest SHALL equal 1 exactly when the state is CLEAR or reset is active.
REQ-017 On the first edge with reset low, the state SHALL go to CLEAR with fill counter = DEPTH-1 when CLEAR_ON_RESET=1, and to READY otherwise.
REQ-018 In CLEAR, each cycle SHALL write all-zero to the word at the fill counter and decrement the counter.
REQ-019 After the word at address 0 is written, the state SHALL go to READY; a fill therefore SHALL take exactly DEPTH cycles.
REQ-020 A clear pulse sampled in READY SHALL enter CLEAR with counter = DEPTH-1, for any CLEAR_ON_RESET value.
REQ-021 A clear pulse sampled in CLEAR SHALL be ignored; the fill in progress SHALL NOT restart.
REQ-022 A write SHALL be accepted only when wr_write=1, wr_waitrequest=0, and wr_address<DEPTH; all other write requests SHALL be dropped with no memory change.
REQ-023 An accepted write SHALL update only the bytes whose wr_byteenable bit is 1; wr_byteenable=0 SHALL leave the word unchanged.
REQ-024 Read latency: rd_address sampled at edge n SHALL produce the corresponding rd_readdata after edge n, stable for one cycle; all ports SHALL be independent.
REQ-025 Lookahead bypass: if an accepted write at edge n targets the read address of port i, port i SHALL return, after edge n, the memory word with the enabled bytes replaced by the edge-n wr_writedata bytes.
REQ-026 The bypass SHALL apply to every port that matches the write address in the same cycle.
REQ-027 A read with address >= DEPTH SHALL return 0.
REQ-028 A read sampled while the state is CLEAR SHALL return 0.
REQ-029 Without a write or clear, a read SHALL return the last written value; memory contents SHALL persist across reset when CLEAR_ON_RESET=0.
REQ-030 No write or read path SHALL be combinational from input to output; rd_readdata and wr_waitrequest SHALL be driven from registers only.

Reset
REQ-031 While reset=1: wr_waitrequest=1, rd_readdata=0, fill counter=DEPTH-1, and memory writes suppressed.
REQ-032 Reset asserted mid-fill SHALL abort the fill; on release, the fill SHALL restart from DEPTH-1 if CLEAR_ON_RESET=1, otherwise go directly to READY.
REQ-033 Reset SHALL take priority over clear and wr_write in the same cycle.

Verification
REQ-034 DEPTH=16, CLEAR_ON_RESET=1: release reset -> wr_waitrequest=1 for exactly 16 cycles, then 0; all 16 addresses read 0 on both ports.
REQ-035 Write 0xA5A5A5A5 to addr 3, byteenable=4'b0101, over prior 0x11223344, with port 0 reading addr 3 on the same edge -> next cycle port 0=0x11A533A5; port 1 reading addr 4 is unaffected.
REQ-036 DEPTH=10: write to addr 12 -> dropped; a read of addr 12 returns 0; addr 0..9 unchanged.
REQ-037 Pulse clear in READY after filling addresses with 0xFFFFFFFF -> wr_waitrequest=1 for 16 cycles; a write during fill is dropped; afterwards all words read 0.
REQ-038 Reset asserted 5 cycles into a fill, held 1 cycle -> fill restarts and wr_waitrequest stays 1 for a further 16 cycles after release.
REQ-039 CLEAR_ON_RESET=0, NUM_RD_PORTS=4: random 1000-cycle write/read mix checked against a byte-accurate model including same-cycle bypass on all ports; wr_waitrequest=0 one cycle after reset release.

Source files
------------

// File: rtl/lookahead_multiport_ram.sv
// Multi-read-port RAM with one byte-enabled write port, a registered read path
// and same-cycle write-to-read bypass. A background zero fill runs after reset
// (optional) or on a clear pulse. While the fill runs, writes stall and reads return zero.
module lookahead_multiport_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int NUM_RD_PORTS   = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDRESS_WIDTH-1:0]              wr_address,
  input  logic [DATA_WIDTH-1:0]                 wr_writedata,
  input  logic [BE_WIDTH-1:0]                   wr_byteenable,
  input  logic                                  wr_write,
  output logic                                  wr_waitrequest,
  input  logic                                  clear,
  input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_readdata
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

  // ST_RESET holds while reset is high so that the first edge after release
  // only decides between filling and going ready, without touching memory.
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_e;

  state_e                               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]             cnt_q, cnt_d;
  logic                                 wr_waitrequest_q, wr_waitrequest_d;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_readdata_q, rd_readdata_d;
  logic [DATA_WIDTH-1:0]                mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]                wr_mask;
  logic                                 wr_accept;
  logic                                 mem_we;
  logic [ADDRESS_WIDTH-1:0]             mem_waddr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic [DATA_WIDTH-1:0]                mem_wmask;
  logic [ADDRESS_WIDTH-1:0]             rd_addr;
  logic [DATA_WIDTH-1:0]                rd_word;

  // Fill sequencing: next state, fill counter and busy flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        cnt_d   = LAST_ADDR;
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        if (cnt_q == '0) state_d = ST_READY;
        else             cnt_d   = cnt_q - ADDR_ONE;
      end
      ST_READY: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = LAST_ADDR;
        end
      end
      default: state_d = ST_RESET;
    endcase
    wr_waitrequest_d = (state_d != ST_READY);
  end

  // Write acceptance, byte mask and the single memory write port (fill has priority)
  always_comb begin
    wr_mask = '0;
    for (int unsigned k = 0; k < BE_WIDTH; k++) begin
      wr_mask[k*8 +: 8] = {8{wr_byteenable[k]}};
    end
    wr_accept = !reset && wr_write && !wr_waitrequest_q && (int'(wr_address) < DEPTH);
    mem_we    = 1'b0;
    mem_waddr = wr_address;
    mem_wdata = wr_writedata;
    mem_wmask = wr_mask;
    if (!reset && state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else if (wr_accept) begin
      mem_we    = 1'b1;
    end
  end

  // Per-port read data with the accepted write merged in when addresses match
  always_comb begin
    rd_readdata_d = '0;
    rd_addr       = '0;
    rd_word       = '0;
    for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
      rd_addr = rd_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      rd_word = '0;
      if (!reset && state_q != ST_CLEAR && int'(rd_addr) < DEPTH) begin
        rd_word = mem_q[rd_addr];
        if (wr_accept && wr_address == rd_addr) begin
          rd_word = (rd_word & ~wr_mask) | (wr_writedata & wr_mask);
        end
      end
      rd_readdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_word;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_RESET;
      cnt_q            <= LAST_ADDR;
      wr_waitrequest_q <= 1'b1;
      rd_readdata_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      wr_waitrequest_q <= wr_waitrequest_d;
      rd_readdata_q    <= rd_readdata_d;
    end
  end

  // Storage array; contents are not reset so they persist when no fill runs
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  assign wr_waitrequest = wr_waitrequest_q;
  assign rd_readdata    = rd_readdata_q;

endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// Bench for lookahead_multiport_ram: three instances cover the default
// configuration, a non-power-of-two depth, and a no-fill four-port variant.
module tb_lookahead_multiport_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: DEPTH 16, 2 ports, fill on reset
  logic        a_reset, a_wr_write, a_wait, a_clear;
  logic [3:0]  a_wr_address, a_wr_be;
  logic [31:0] a_wr_writedata;
  logic [7:0]  a_rd_address;
  logic [63:0] a_rd_readdata;

  // Instance B: DEPTH 10, 2 ports, fill on reset
  logic        b_reset, b_wr_write, b_wait, b_clear;
  logic [3:0]  b_wr_address, b_wr_be;
  logic [31:0] b_wr_writedata;
  logic [7:0]  b_rd_address;
  logic [63:0] b_rd_readdata;

  // Instance C: DEPTH 16, 4 ports, no fill on reset
  logic         c_reset, c_wr_write, c_wait, c_clear;
  logic [3:0]   c_wr_address, c_wr_be;
  logic [31:0]  c_wr_writedata;
  logic [15:0]  c_rd_address;
  logic [127:0] c_rd_readdata;

  logic [31:0] b_model [10];
  logic [31:0] c_model [16];

  lookahead_multiport_ram #(.DATA_WIDTH(32), .DEPTH(16), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(a_reset), .wr_address(a_wr_address), .wr_writedata(a_wr_writedata),
    .wr_byteenable(a_wr_be), .wr_write(a_wr_write), .wr_waitrequest(a_wait), .clear(a_clear),
    .rd_address(a_rd_address), .rd_readdata(a_rd_readdata));

  lookahead_multiport_ram #(.DATA_WIDTH(32), .DEPTH(10), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(b_reset), .wr_address(b_wr_address), .wr_writedata(b_wr_writedata),
    .wr_byteenable(b_wr_be), .wr_write(b_wr_write), .wr_waitrequest(b_wait), .clear(b_clear),
    .rd_address(b_rd_address), .rd_readdata(b_rd_readdata));

  lookahead_multiport_ram #(.DATA_WIDTH(32), .DEPTH(16), .NUM_RD_PORTS(4), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .reset(c_reset), .wr_address(c_wr_address), .wr_writedata(c_wr_writedata),
    .wr_byteenable(c_wr_be), .wr_write(c_wr_write), .wr_waitrequest(c_wait), .clear(c_clear),
    .rd_address(c_rd_address), .rd_readdata(c_rd_readdata));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_reset = 1; b_reset = 1; c_reset = 1;
    tick; tick;
    n_total++; if (a_wait !== 1'b1) $display("FAIL reset_a_wait got %0b want 1", a_wait); else n_pass++;
    n_total++; if (a_rd_readdata !== 64'h0) $display("FAIL reset_a_rd got %h want 0", a_rd_readdata); else n_pass++;
    n_total++; if (b_wait !== 1'b1) $display("FAIL reset_b_wait got %0b want 1", b_wait); else n_pass++;
    n_total++; if (c_wait !== 1'b1) $display("FAIL reset_c_wait got %0b want 1", c_wait); else n_pass++;
    n_total++; if (c_rd_readdata !== 128'h0) $display("FAIL reset_c_rd got %h want 0", c_rd_readdata); else n_pass++;
  endtask

  // Busy must last exactly DEPTH cycles after reset release, then every word reads zero
  task automatic test_fill_after_reset;
    int na, nb;
    na = 0; nb = 0;
    a_reset = 0; b_reset = 0;
    tick;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (a_wait) na++;
      if (b_wait) nb++;
      tick;
    end
    n_total++; if (na != 16) $display("FAIL fill_a_cycles got %0d want 16", na); else n_pass++;
    n_total++; if (nb != 10) $display("FAIL fill_b_cycles got %0d want 10", nb); else n_pass++;
    n_total++; if (a_wait !== 1'b0) $display("FAIL fill_a_wait_end got %0b want 0", a_wait); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      a_rd_address = {4'(15 - a), 4'(a)};
      tick;
      n_total++;
      if (a_rd_readdata !== 64'h0) $display("FAIL fill_a_zero addr %0d got %h want 0", a, a_rd_readdata);
      else n_pass++;
    end
  endtask

  task automatic test_byteenable;
    a_wr_write = 1; a_wr_be = 4'hF;
    a_wr_address = 4; a_wr_writedata = 32'hCAFEF00D; tick;
    a_wr_address = 3; a_wr_writedata = 32'h11223344; tick;
    a_wr_address = 3; a_wr_writedata = 32'hA5A5A5A5; a_wr_be = 4'b0101;
    a_rd_address = {4'd4, 4'd3};
    tick;
    a_wr_write = 0;
    n_total++; if (a_rd_readdata[31:0] !== 32'h11A533A5) $display("FAIL be_bypass_p0 got %h want 11a533a5", a_rd_readdata[31:0]); else n_pass++;
    n_total++; if (a_rd_readdata[63:32] !== 32'hCAFEF00D) $display("FAIL be_bypass_p1 got %h want cafef00d", a_rd_readdata[63:32]); else n_pass++;
    a_wr_address = 3; a_wr_writedata = 32'h0; a_wr_be = 4'b0000; a_wr_write = 1;
    tick;
    a_wr_write = 0;
    n_total++; if (a_rd_readdata[31:0] !== 32'h11A533A5) $display("FAIL be_none got %h want 11a533a5", a_rd_readdata[31:0]); else n_pass++;
    tick;
    n_total++; if (a_rd_readdata[31:0] !== 32'h11A533A5) $display("FAIL be_stored got %h want 11a533a5", a_rd_readdata[31:0]); else n_pass++;
  endtask

  // Clear from READY, with a dropped write and an ignored second clear inside the fill
  task automatic test_clear;
    int n;
    for (int a = 0; a < 16; a++) begin
      a_wr_write = 1; a_wr_be = 4'hF; a_wr_address = 4'(a); a_wr_writedata = 32'hFFFFFFFF;
      tick;
    end
    a_wr_write = 0;
    a_clear = 1; tick; a_clear = 0;
    n_total++; if (a_wait !== 1'b1) $display("FAIL clear_wait_start got %0b want 1", a_wait); else n_pass++;
    n = 0;
    for (int cyc = 0; cyc < 100 && a_wait; cyc++) begin
      n++;
      a_wr_write = (n == 3); a_wr_address = 4'd15; a_wr_writedata = 32'h12345678; a_wr_be = 4'hF;
      a_clear = (n == 6);
      a_rd_address = {4'd0, 4'd10};
      tick;
      n_total++;
      if (a_rd_readdata[31:0] !== 32'h0) $display("FAIL clear_rd_busy cyc %0d got %h want 0", n, a_rd_readdata[31:0]);
      else n_pass++;
    end
    a_wr_write = 0; a_clear = 0;
    n_total++; if (n != 16) $display("FAIL clear_cycles got %0d want 16", n); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      a_rd_address = {4'(15 - a), 4'(a)};
      tick;
      n_total++;
      if (a_rd_readdata !== 64'h0) $display("FAIL clear_zero addr %0d got %h want 0", a, a_rd_readdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fill;
    int n;
    a_clear = 1; tick; a_clear = 0;
    repeat (4) tick;
    a_reset = 1; a_clear = 1; a_wr_write = 1; a_wr_address = 4'd2; a_wr_writedata = 32'h5A5A5A5A;
    a_rd_address = {4'd1, 4'd2};
    tick;
    a_reset = 0; a_clear = 0; a_wr_write = 0;
    n_total++; if (a_wait !== 1'b1) $display("FAIL midfill_reset_wait got %0b want 1", a_wait); else n_pass++;
    n_total++; if (a_rd_readdata !== 64'h0) $display("FAIL midfill_reset_rd got %h want 0", a_rd_readdata); else n_pass++;
    tick;
    n = 0;
    for (int cyc = 0; cyc < 100 && a_wait; cyc++) begin
      n++;
      tick;
    end
    n_total++; if (n != 16) $display("FAIL midfill_restart_cycles got %0d want 16", n); else n_pass++;
    tick;
    n_total++; if (a_rd_readdata !== 64'h0) $display("FAIL midfill_mem got %h want 0", a_rd_readdata); else n_pass++;
  endtask

  // Non-power-of-two depth: out-of-range writes dropped, out-of-range reads zero
  task automatic test_out_of_range;
    for (int a = 0; a < 10; a++) begin
      b_model[a] = $urandom;
      b_wr_write = 1; b_wr_be = 4'hF; b_wr_address = 4'(a); b_wr_writedata = b_model[a];
      tick;
    end
    b_wr_address = 4'd12; b_wr_writedata = 32'hDEADBEEF;
    b_rd_address = {4'd9, 4'd12};
    tick;
    b_wr_write = 0;
    n_total++; if (b_rd_readdata[31:0] !== 32'h0) $display("FAIL oor_read12 got %h want 0", b_rd_readdata[31:0]); else n_pass++;
    n_total++; if (b_rd_readdata[63:32] !== b_model[9]) $display("FAIL oor_read9 got %h want %h", b_rd_readdata[63:32], b_model[9]); else n_pass++;
    for (int a = 0; a < 10; a++) begin
      b_rd_address = {4'(10 + (a % 6)), 4'(a)};
      tick;
      n_total++;
      if (b_rd_readdata[31:0] !== b_model[a]) $display("FAIL oor_keep addr %0d got %h want %h", a, b_rd_readdata[31:0], b_model[a]);
      else n_pass++;
      n_total++;
      if (b_rd_readdata[63:32] !== 32'h0) $display("FAIL oor_high addr %0d got %h want 0", 10 + (a % 6), b_rd_readdata[63:32]);
      else n_pass++;
    end
  endtask

  // Random write/read mix on four ports against a byte-level model
  task automatic test_random_bypass;
    logic [3:0]  wa;
    logic [3:0]  ra [4];
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] exp_rd [4];
    c_reset = 0;
    tick;
    n_total++; if (c_wait !== 1'b0) $display("FAIL nofill_wait got %0b want 0", c_wait); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      c_model[a] = $urandom;
      c_wr_write = 1; c_wr_be = 4'hF; c_wr_address = 4'(a); c_wr_writedata = c_model[a];
      tick;
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      wa = 4'($urandom_range(0, 15));
      we = ($urandom_range(0, 3) != 0);
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      for (int i = 0; i < 4; i++) ra[i] = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      c_wr_address = wa; c_wr_write = we; c_wr_be = be; c_wr_writedata = wd;
      for (int i = 0; i < 4; i++) c_rd_address[i*4 +: 4] = ra[i];
      if (we && !c_wait) begin
        for (int k = 0; k < 4; k++) if (be[k]) c_model[wa][k*8 +: 8] = wd[k*8 +: 8];
      end
      for (int i = 0; i < 4; i++) exp_rd[i] = c_model[ra[i]];
      tick;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (c_rd_readdata[i*32 +: 32] !== exp_rd[i])
          $display("FAIL rand_rd cyc %0d port %0d addr %0d got %h want %h", cyc, i, ra[i], c_rd_readdata[i*32 +: 32], exp_rd[i]);
        else n_pass++;
      end
    end
    c_wr_write = 0;
  endtask

  task automatic test_persist_and_clear;
    int n;
    c_reset = 1; c_wr_write = 1; c_clear = 1; c_wr_address = 4'd0; c_wr_writedata = 32'h0BADF00D; c_wr_be = 4'hF;
    tick; tick;
    c_wr_write = 0; c_clear = 0;
    n_total++; if (c_wait !== 1'b1) $display("FAIL persist_reset_wait got %0b want 1", c_wait); else n_pass++;
    n_total++; if (c_rd_readdata !== 128'h0) $display("FAIL persist_reset_rd got %h want 0", c_rd_readdata); else n_pass++;
    c_reset = 0;
    tick;
    n_total++; if (c_wait !== 1'b0) $display("FAIL persist_release_wait got %0b want 0", c_wait); else n_pass++;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) c_rd_address[i*4 +: 4] = 4'(g*4 + i);
      tick;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (c_rd_readdata[i*32 +: 32] !== c_model[g*4 + i])
          $display("FAIL persist_mem addr %0d got %h want %h", g*4 + i, c_rd_readdata[i*32 +: 32], c_model[g*4 + i]);
        else n_pass++;
      end
    end
    c_clear = 1; tick; c_clear = 0;
    n = 0;
    for (int cyc = 0; cyc < 100 && c_wait; cyc++) begin
      n++;
      tick;
    end
    n_total++; if (n != 16) $display("FAIL c_clear_cycles got %0d want 16", n); else n_pass++;
    for (int a = 0; a < 16; a++) c_model[a] = 32'h0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) c_rd_address[i*4 +: 4] = 4'(g*4 + i);
      tick;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (c_rd_readdata[i*32 +: 32] !== c_model[g*4 + i])
          $display("FAIL c_clear_mem addr %0d got %h want %h", g*4 + i, c_rd_readdata[i*32 +: 32], c_model[g*4 + i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    a_reset = 1; a_wr_write = 0; a_clear = 0; a_wr_address = '0; a_wr_be = '0; a_wr_writedata = '0; a_rd_address = '0;
    b_reset = 1; b_wr_write = 0; b_clear = 0; b_wr_address = '0; b_wr_be = '0; b_wr_writedata = '0; b_rd_address = '0;
    c_reset = 1; c_wr_write = 0; c_clear = 0; c_wr_address = '0; c_wr_be = '0; c_wr_writedata = '0; c_rd_address = '0;
    test_reset;
    test_fill_after_reset;
    test_byteenable;
    test_clear;
    test_reset_mid_fill;
    test_out_of_range;
    test_random_bypass;
    test_persist_and_clear;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
